hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit_pkg.sv | 37 +++
 rtl/hilo_muldiv_unit_core.sv | 84 ++++++++
 rtl/hilo_muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared CPU package for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding, iteration count and a conditional two's-complement helper.
package hilo_muldiv_unit_pkg;

    // Number of quotient bits (or shift-add steps) per iterative operation.
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Two's-complement negate of a 32-bit value when en is set.
    function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    // Two's-complement negate of a 64-bit value when en is set.
    function automatic logic [63:0] neg64_if(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_core.sv
// muldiv_iter_core: unsigned iterative datapath shared by divide and
// (optionally) multiply. Divide is restoring, one quotient bit per step with
// the dividend shifted out of lo while quotient bits shift in. Multiply is
// shift-add with the multiplier in lo and the product growing from hi.
module muldiv_iter_core
    import hilo_muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,      // capture operands, clear counter
    input  logic        step,      // perform one iteration
    input  logic        mul_mode,  // sampled with load: 1 = multiply, 0 = divide
    input  logic [31:0] op_a,      // dividend / multiplicand magnitude
    input  logic [31:0] op_b,      // divisor / multiplier magnitude
    output logic [31:0] hi_o,      // remainder / product high word
    output logic [31:0] lo_o,      // quotient / product low word
    output logic        last_o     // current step is the final one
);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      opnd_q, opnd_d;
    logic             mul_q, mul_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      trial;
    logic [32:0]      acc;

    // Next-state for one load or iteration of the shift/subtract or shift/add datapath.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        mul_d  = mul_q;
        cnt_d  = cnt_q;
        // Partial remainder shifted left by one with the next dividend bit, minus divisor.
        trial  = {hi_q, lo_q[31]} - {1'b0, opnd_q};
        // Partial product plus multiplicand when the current multiplier bit is set.
        acc    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);

        if (load) begin
            hi_d   = '0;
            lo_d   = mul_mode ? op_b : op_a;
            opnd_d = mul_mode ? op_a : op_b;
            mul_d  = mul_mode;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mul_q) begin
                hi_d = acc[32:1];
                lo_d = {acc[0], lo_q[31:1]};
            end else if (!trial[32]) begin
                hi_d = trial[31:0];
                lo_d = {lo_q[30:0], 1'b1};
            end else begin
                hi_d = {hi_q[30:0], lo_q[31]};
                lo_d = {lo_q[30:0], 1'b0};
            end
        end
    end

    // Datapath and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            mul_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            mul_q  <= mul_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign last_o = (cnt_q == CNT_W'(DIV_ITERS - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: MIPS-style HI/LO multiply/divide unit. Owns the control FSM,
// operand sign handling and the architectural HI/LO registers; iterations run in
// muldiv_iter_core on magnitudes, and signs are restored in the FIX state.
// Build option: define HILO_ITERATIVE_MULT_EN for a 32-cycle shift-add multiply;
// otherwise MULT/MULTU complete combinationally at the accepting edge.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] HI_reg,
    output logic [XLEN-1:0] LO_reg
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            is_mul_q, is_mul_d;  // operation in flight is a multiply
    logic            neg_lo_q, neg_lo_d;  // negate quotient / product at FIX
    logic            neg_hi_q, neg_hi_d;  // negate remainder at FIX
    logic            div0_q, div0_d;      // divisor was zero

    op_e             op_s;
    logic            signed_op;
    logic            sign_lo;
    logic [31:0]     rs_mag;
    logic [31:0]     rt_mag;
    logic [63:0]     fix_prod;

    logic            core_load;
    logic            core_step;
    logic            core_mul;
    logic [31:0]     core_hi;
    logic [31:0]     core_lo;
    logic            core_last;

    assign op_s      = op_e'(op);
    assign signed_op = (op_s == OP_MULT) || (op_s == OP_DIV);
    assign sign_lo   = signed_op & (rs_val[31] ^ rt_val[31]);
    assign rs_mag    = neg32_if(rs_val, signed_op & rs_val[31]);
    assign rt_mag    = neg32_if(rt_val, signed_op & rt_val[31]);
    assign fix_prod  = neg64_if({core_hi, core_lo}, neg_lo_q);

`ifndef HILO_ITERATIVE_MULT_EN
    logic [63:0] prod_now;
    // Single-cycle product of the magnitudes, sign applied afterwards.
    assign prod_now = neg64_if({32'd0, rs_mag} * {32'd0, rt_mag}, sign_lo);
`endif

    muldiv_iter_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (core_load),
        .step     (core_step),
        .mul_mode (core_mul),
        .op_a     (rs_mag),
        .op_b     (rt_mag),
        .hi_o     (core_hi),
        .lo_o     (core_lo),
        .last_o   (core_last)
    );

    // Control FSM: accept requests in IDLE, iterate, then sign-fix and commit HI/LO.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_mul_d  = is_mul_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        div0_d    = div0_q;
        core_load = 1'b0;
        core_step = 1'b0;
        core_mul  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_s)
                        OP_MULT, OP_MULTU: begin
`ifdef HILO_ITERATIVE_MULT_EN
                            core_load = 1'b1;
                            core_mul  = 1'b1;
                            is_mul_d  = 1'b1;
                            neg_lo_d  = sign_lo;
                            state_d   = ST_MUL;
`else
                            {hi_d, lo_d} = prod_now;
                            done_d       = 1'b1;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            core_load = 1'b1;
                            is_mul_d  = 1'b0;
                            neg_lo_d  = sign_lo;
                            neg_hi_d  = signed_op & rs_val[31];
                            div0_d    = (rt_val == '0);
                            state_d   = ST_DIV;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (is_mul_q) begin
                    {hi_d, lo_d} = fix_prod;
                end else begin
                    // Divide by zero returns all-ones quotient; remainder is the dividend.
                    lo_d = div0_q ? '1 : neg32_if(core_lo, neg_lo_q);
                    hi_d = neg32_if(core_hi, neg_hi_q);
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, architectural HI/LO and completion pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            is_mul_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            is_mul_q <= is_mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign HI_reg = hi_q;
    assign LO_reg = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected results
// computed with plain arithmetic; a negedge monitor checks busy, done, HI and LO.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;
    localparam int DIV_LAT = 33;
    localparam int MUL_LAT =
`ifdef HILO_ITERATIVE_MULT_EN
        33;
`else
        0;
`endif

    typedef struct {
        logic [63:0] exp;
        int          e0;
        int          lat;
        string       name;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    item_t       sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;

    hilo_muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .HI_reg (hi_reg),
        .LO_reg (lo_reg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: {HI, LO} from the architectural definition of each op.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int                sa, sb_, q, r;
        longint            sp;
        longint unsigned   ua, ub;
        logic [63:0]       res;
        sa = a;
        sb_ = b;
        res = '0;
        case (o)
            MULT: begin
                sp  = longint'(sa) * longint'(sb_);
                res = sp;
            end
            MULTU: begin
                ua  = a;
                ub  = b;
                res = ua * ub;
            end
            DIV: begin
                if (b == 0)                                  res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == '1)      res = {32'h0, 32'h8000_0000};
                else begin
                    q   = sa / sb_;
                    r   = sa % sb_;
                    res = {r, q};
                end
            end
            DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Drive one start pulse; if it should be accepted, record its expected effect.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit accept, input string name);
        item_t it;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 3'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        if (accept) begin
            case (o)
                MULT, MULTU, DIV, DIVU: begin
                    it.exp  = ref_op(o, a, b);
                    it.e0   = cyc;
                    it.lat  = (o == DIV || o == DIVU) ? DIV_LAT : MUL_LAT;
                    it.name = name;
                    sb.push_back(it);
                end
                MTHI:    arch_hi = a;
                MTLO:    arch_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: busy/done timing and HI/LO value on every falling edge.
    always @(negedge clk) begin
        bit    exp_busy;
        bit    exp_done;
        item_t it;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sb.size() > 0) begin
            exp_done = (cyc == sb[0].e0 + sb[0].lat);
            exp_busy = (sb[0].lat > 0) && (cyc < sb[0].e0 + sb[0].lat);
        end
        check("busy", 64'(busy), 64'(exp_busy));
        check("done", 64'(done), 64'(exp_done));
        if (exp_done) begin
            it = sb.pop_front();
            check({it.name, " HI"}, 64'(hi_reg), 64'(it.exp[63:32]));
            check({it.name, " LO"}, 64'(lo_reg), 64'(it.exp[31:0]));
            arch_hi = it.exp[63:32];
            arch_lo = it.exp[31:0];
        end else begin
            check("HI hold", 64'(hi_reg), 64'(arch_hi));
            check("LO hold", 64'(lo_reg), 64'(arch_lo));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;

        // Power-on reset.
        #1 rst_n = 1'b0;
        #2;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset HI", 64'(hi_reg), 64'd0);
        check("reset LO", 64'(lo_reg), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed cases.
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "DIV -7/2");
        wait_idle();
        issue(DIVU, 32'd100, 32'd0, 1'b1, "DIVU 100/0");
        wait_idle();
        issue(MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, "MULT -1*2");
        wait_idle();
        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, "MULTU ffffffff*2");
        wait_idle();
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "DIV min/-1");
        wait_idle();
        issue(DIV, 32'hFFFF_FF9C, 32'd0, 1'b1, "DIV -100/0");
        wait_idle();

        // MTHI while busy is ignored; after completion it lands at the next edge.
        issue(DIV, 32'd1000, 32'd7, 1'b1, "DIV 1000/7");
        repeat (3) @(negedge clk);
        issue(MTHI, 32'h1234_5678, 32'h0, 1'b0, "MTHI busy");
        wait_idle();
        issue(MTHI, 32'h1234_5678, 32'h0, 1'b1, "MTHI");
        check("MTHI HI", 64'(hi_reg), 64'h1234_5678);
        issue(MTLO, 32'hCAFE_F00D, 32'h0, 1'b1, "MTLO");
        check("MTLO LO", 64'(lo_reg), 64'hCAFE_F00D);

        // Asynchronous reset at cycle 10 of a divide.
        issue(DIV, 32'h7654_3210, 32'd3, 1'b1, "DIV reset");
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        arch_hi = '0;
        arch_lo = '0;
        #1;
        check("midop reset busy", 64'(busy), 64'd0);
        check("midop reset done", 64'(done), 64'd0);
        check("midop reset HI", 64'(hi_reg), 64'd0);
        check("midop reset LO", 64'(lo_reg), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        // First edge after release must accept.
        issue(MTLO, 32'h0BAD_BEEF, 32'h0, 1'b1, "MTLO after reset");
        check("first start LO", 64'(lo_reg), 64'h0BAD_BEEF);
        repeat (40) @(negedge clk);

        // Randomized operations, some with a request issued mid-flight.
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = rnd_val();
            b = rnd_val();
            issue(o, a, b, 1'b1, "random");
            if ((o == DIV || o == DIVU) && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 25)) @(negedge clk);
                issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'b0, "ignored");
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
